// File: rtl/mips_fetch_pkg.sv
// Shared fetch-stage constants and the fetch FSM state type, also used by the
// decode stage and the hazard unit.
package mips_fetch_pkg;

    localparam int              PC_W     = 6;
    localparam int              INSTR_W  = 16;
    localparam logic [5:0]      RESET_PC = 6'd0;
    localparam logic [15:0]     NOP      = 16'h0000;
    localparam logic [3:0]      HALT_OPC = 4'hF;

    typedef enum logic {
        FS_RUN    = 1'b0,
        FS_HALTED = 1'b1
    } fetch_state_t;

endpackage

// File: rtl/pc_next_sel.sv
// Combinational next-state select for the fetch stage: chooses the next PC,
// IF/ID contents and FSM state from redirect, stall and the current state.
module pc_next_sel
    import mips_fetch_pkg::*;
#(
    parameter int                 PC_W     = mips_fetch_pkg::PC_W,
    parameter int                 INSTR_W  = mips_fetch_pkg::INSTR_W,
    parameter logic [INSTR_W-1:0] NOP      = mips_fetch_pkg::NOP,
    parameter logic [3:0]         HALT_OPC = mips_fetch_pkg::HALT_OPC
) (
    input  logic [PC_W-1:0]    i_pc,
    input  fetch_state_t       i_state,
    input  logic [INSTR_W-1:0] i_instr,
    input  logic               i_stall,
    input  logic               i_branch_taken,
    input  logic [PC_W-1:0]    i_branch_target,
    input  logic               i_jump,
    input  logic [PC_W-1:0]    i_jump_target,
    input  logic [INSTR_W-1:0] i_ifid_instr,
    input  logic [PC_W-1:0]    i_ifid_pc1,
    input  logic               i_ifid_valid,
    output logic [PC_W-1:0]    o_pc_next,
    output logic [INSTR_W-1:0] o_ifid_instr_next,
    output logic [PC_W-1:0]    o_ifid_pc1_next,
    output logic               o_ifid_valid_next,
    output fetch_state_t       o_state_next
);

    logic [PC_W-1:0] w_pc_inc;
    logic            w_is_halt;

    // Modulo 2^PC_W increment; wrap from the top address is intentional.
    assign w_pc_inc  = i_pc + PC_W'(1);
    assign w_is_halt = (i_instr[INSTR_W-1 -: 4] == HALT_OPC);

    always_comb begin
        o_pc_next         = i_pc;
        o_ifid_instr_next = i_ifid_instr;
        o_ifid_pc1_next   = i_ifid_pc1;
        o_ifid_valid_next = i_ifid_valid;
        o_state_next      = i_state;

        // Branch comes from the older instruction, so it wins over a jump.
        if (i_branch_taken || i_jump) begin
            o_pc_next         = i_branch_taken ? i_branch_target : i_jump_target;
            o_ifid_instr_next = NOP;
            o_ifid_pc1_next   = '0;
            o_ifid_valid_next = 1'b0;
            o_state_next      = FS_RUN;
        end else if (!i_stall) begin
            case (i_state)
                FS_RUN: begin
                    o_ifid_instr_next = i_instr;
                    o_ifid_pc1_next   = w_pc_inc;
                    o_ifid_valid_next = 1'b1;
                    if (w_is_halt) begin
                        o_state_next = FS_HALTED;
                    end else begin
                        o_pc_next = w_pc_inc;
                    end
                end
                FS_HALTED: begin
                    o_ifid_instr_next = NOP;
                    o_ifid_pc1_next   = '0;
                    o_ifid_valid_next = 1'b0;
                end
                default: begin
                    o_state_next = FS_RUN;
                end
            endcase
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, drives the instruction memory address
// and captures the returned instruction into the IF/ID pipeline register.
module fetch_unit
    import mips_fetch_pkg::*;
#(
    parameter int                 PC_W     = mips_fetch_pkg::PC_W,
    parameter int                 INSTR_W  = mips_fetch_pkg::INSTR_W,
    parameter logic [PC_W-1:0]    RESET_PC = mips_fetch_pkg::RESET_PC,
    parameter logic [INSTR_W-1:0] NOP      = mips_fetch_pkg::NOP,
    parameter logic [3:0]         HALT_OPC = mips_fetch_pkg::HALT_OPC
) (
    input  logic               CLK,
    input  logic               RST,
    output logic [PC_W-1:0]    PCI,
    input  logic [INSTR_W-1:0] INSTR,
    input  logic               STALL,
    input  logic               BRANCH_TAKEN,
    input  logic [PC_W-1:0]    BRANCH_TARGET,
    input  logic               JUMP,
    input  logic [PC_W-1:0]    JUMP_TARGET,
    output logic [INSTR_W-1:0] IFID_INSTR,
    output logic [PC_W-1:0]    IFID_PC1,
    output logic               IFID_VALID,
    output logic               HALTED
);

    logic [PC_W-1:0]    r_pc;
    logic [INSTR_W-1:0] r_ifid_instr;
    logic [PC_W-1:0]    r_ifid_pc1;
    logic               r_ifid_valid;
    fetch_state_t       r_state;
    logic               r_halted;

    logic [PC_W-1:0]    w_pc_next;
    logic [INSTR_W-1:0] w_ifid_instr_next;
    logic [PC_W-1:0]    w_ifid_pc1_next;
    logic               w_ifid_valid_next;
    fetch_state_t       w_state_next;

    pc_next_sel #(
        .PC_W     (PC_W),
        .INSTR_W  (INSTR_W),
        .NOP      (NOP),
        .HALT_OPC (HALT_OPC)
    ) u_pc_next_sel (
        .i_pc              (r_pc),
        .i_state           (r_state),
        .i_instr           (INSTR),
        .i_stall           (STALL),
        .i_branch_taken    (BRANCH_TAKEN),
        .i_branch_target   (BRANCH_TARGET),
        .i_jump            (JUMP),
        .i_jump_target     (JUMP_TARGET),
        .i_ifid_instr      (r_ifid_instr),
        .i_ifid_pc1        (r_ifid_pc1),
        .i_ifid_valid      (r_ifid_valid),
        .o_pc_next         (w_pc_next),
        .o_ifid_instr_next (w_ifid_instr_next),
        .o_ifid_pc1_next   (w_ifid_pc1_next),
        .o_ifid_valid_next (w_ifid_valid_next),
        .o_state_next      (w_state_next)
    );

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_pc         <= RESET_PC;
            r_ifid_instr <= NOP;
            r_ifid_pc1   <= '0;
            r_ifid_valid <= 1'b0;
            r_state      <= FS_RUN;
            r_halted     <= 1'b0;
        end else begin
            r_pc         <= w_pc_next;
            r_ifid_instr <= w_ifid_instr_next;
            r_ifid_pc1   <= w_ifid_pc1_next;
            r_ifid_valid <= w_ifid_valid_next;
            r_state      <= w_state_next;
            // Registered copy of the state decode keeps HALTED glitch-free.
            r_halted     <= (w_state_next == FS_HALTED);
        end
    end

    assign PCI        = r_pc;
    assign IFID_INSTR = r_ifid_instr;
    assign IFID_PC1   = r_ifid_pc1;
    assign IFID_VALID = r_ifid_valid;
    assign HALTED     = r_halted;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit with a combinational instruction-memory model.
module tb_fetch_unit;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic [5:0]  PCI;
    logic [15:0] INSTR;
    logic        STALL = 1'b0;
    logic        BRANCH_TAKEN = 1'b0;
    logic [5:0]  BRANCH_TARGET = 6'd0;
    logic        JUMP = 1'b0;
    logic [5:0]  JUMP_TARGET = 6'd0;
    logic [15:0] IFID_INSTR;
    logic [5:0]  IFID_PC1;
    logic        IFID_VALID;
    logic        HALTED;

    logic [15:0] mem [0:63];
    int          vectors = 0;
    int          miscompares = 0;
    logic [29:0] obs;
    logic [29:0] exp_v;

    always #5 CLK = ~CLK;

    assign INSTR = mem[PCI];

    fetch_unit dut (
        .CLK           (CLK),
        .RST           (RST),
        .PCI           (PCI),
        .INSTR         (INSTR),
        .STALL         (STALL),
        .BRANCH_TAKEN  (BRANCH_TAKEN),
        .BRANCH_TARGET (BRANCH_TARGET),
        .JUMP          (JUMP),
        .JUMP_TARGET   (JUMP_TARGET),
        .IFID_INSTR    (IFID_INSTR),
        .IFID_PC1      (IFID_PC1),
        .IFID_VALID    (IFID_VALID),
        .HALTED        (HALTED)
    );

    // Advance one clock; outputs are sampled 1 time unit after the edge.
    task automatic step();
        @(posedge CLK);
        #1;
        obs = {PCI, IFID_INSTR, IFID_PC1, IFID_VALID, HALTED};
    endtask

    task automatic clear_ctrl();
        RST = 1'b0; STALL = 1'b0; BRANCH_TAKEN = 1'b0; JUMP = 1'b0;
    endtask

    task automatic test_reset();
        RST = 1'b1;
        step();
        step();
        exp_v = {6'd0, 16'h0000, 6'd0, 1'b0, 1'b0};
        vectors++;
        if (obs !== exp_v) begin
            miscompares++;
            $display("FAIL reset: got pc=%0d ifid=%h pc1=%0d v=%b h=%b, want pc=0 ifid=0000 pc1=0 v=0 h=0",
                     PCI, IFID_INSTR, IFID_PC1, IFID_VALID, HALTED);
        end
        $display("reset: pc=%0d ifid=%h pc1=%0d v=%b h=%b", PCI, IFID_INSTR, IFID_PC1, IFID_VALID, HALTED);
        clear_ctrl();
    endtask

    task automatic test_sequential();
        for (int k = 0; k < 4; k++) begin
            step();
            exp_v = {6'(k + 1), 16'h1000 + 16'(k), 6'(k + 1), 1'b1, 1'b0};
            vectors++;
            if (obs !== exp_v) begin
                miscompares++;
                $display("FAIL seq%0d: got %h want %h", k, obs, exp_v);
            end
            $display("seq%0d: pc=%0d ifid=%h pc1=%0d v=%b", k, PCI, IFID_INSTR, IFID_PC1, IFID_VALID);
        end
    endtask

    task automatic test_jump_wrap();
        logic [29:0] exp_tab [0:3];
        exp_tab[0] = {6'd62, 16'h0000, 6'd0,  1'b0, 1'b0};
        exp_tab[1] = {6'd63, 16'h103E, 6'd63, 1'b1, 1'b0};
        exp_tab[2] = {6'd0,  16'h103F, 6'd0,  1'b1, 1'b0};
        exp_tab[3] = {6'd1,  16'h1000, 6'd1,  1'b1, 1'b0};
        JUMP = 1'b1; JUMP_TARGET = 6'd62;
        for (int k = 0; k < 4; k++) begin
            step();
            clear_ctrl();
            vectors++;
            if (obs !== exp_tab[k]) begin
                miscompares++;
                $display("FAIL wrap%0d: got %h want %h", k, obs, exp_tab[k]);
            end
            $display("wrap%0d: pc=%0d ifid=%h pc1=%0d v=%b", k, PCI, IFID_INSTR, IFID_PC1, IFID_VALID);
        end
    endtask

    task automatic test_stall();
        logic [29:0] exp_tab [0:4];
        logic        stall_tab [0:4];
        exp_tab[0] = {6'd4, 16'h0000, 6'd0, 1'b0, 1'b0}; stall_tab[0] = 1'b0;
        exp_tab[1] = {6'd5, 16'h1004, 6'd5, 1'b1, 1'b0}; stall_tab[1] = 1'b1;
        exp_tab[2] = {6'd5, 16'h1004, 6'd5, 1'b1, 1'b0}; stall_tab[2] = 1'b1;
        exp_tab[3] = {6'd5, 16'h1004, 6'd5, 1'b1, 1'b0}; stall_tab[3] = 1'b0;
        exp_tab[4] = {6'd6, 16'h1005, 6'd6, 1'b1, 1'b0}; stall_tab[4] = 1'b0;
        JUMP = 1'b1; JUMP_TARGET = 6'd4;
        for (int k = 0; k < 5; k++) begin
            step();
            clear_ctrl();
            STALL = stall_tab[k];
            vectors++;
            if (obs !== exp_tab[k]) begin
                miscompares++;
                $display("FAIL stall%0d: got %h want %h", k, obs, exp_tab[k]);
            end
            $display("stall%0d: pc=%0d ifid=%h pc1=%0d v=%b", k, PCI, IFID_INSTR, IFID_PC1, IFID_VALID);
        end
        clear_ctrl();
    endtask

    task automatic test_priority();
        // Branch beats jump and stall.
        BRANCH_TAKEN = 1'b1; BRANCH_TARGET = 6'd10;
        JUMP = 1'b1; JUMP_TARGET = 6'd20; STALL = 1'b1;
        step();
        exp_v = {6'd10, 16'h0000, 6'd0, 1'b0, 1'b0};
        vectors++;
        if (obs !== exp_v) begin
            miscompares++;
            $display("FAIL prio_branch: got %h want %h", obs, exp_v);
        end
        $display("prio_branch: pc=%0d ifid=%h v=%b", PCI, IFID_INSTR, IFID_VALID);
        // Jump beats stall.
        BRANCH_TAKEN = 1'b0;
        step();
        exp_v = {6'd20, 16'h0000, 6'd0, 1'b0, 1'b0};
        vectors++;
        if (obs !== exp_v) begin
            miscompares++;
            $display("FAIL prio_jump: got %h want %h", obs, exp_v);
        end
        $display("prio_jump: pc=%0d ifid=%h v=%b", PCI, IFID_INSTR, IFID_VALID);
        clear_ctrl();
        step();
        exp_v = {6'd21, 16'h1014, 6'd21, 1'b1, 1'b0};
        vectors++;
        if (obs !== exp_v) begin
            miscompares++;
            $display("FAIL prio_resume: got %h want %h", obs, exp_v);
        end
        $display("prio_resume: pc=%0d ifid=%h pc1=%0d v=%b", PCI, IFID_INSTR, IFID_PC1, IFID_VALID);
    endtask

    task automatic test_halt();
        logic [29:0] exp_tab [0:8];
        exp_tab[0] = {6'd0, 16'h0000, 6'd0, 1'b0, 1'b0};
        exp_tab[1] = {6'd1, 16'h1000, 6'd1, 1'b1, 1'b0};
        exp_tab[2] = {6'd2, 16'h1001, 6'd2, 1'b1, 1'b0};
        exp_tab[3] = {6'd3, 16'h1002, 6'd3, 1'b1, 1'b0};
        exp_tab[4] = {6'd3, 16'hF000, 6'd4, 1'b1, 1'b1};
        exp_tab[5] = {6'd3, 16'h0000, 6'd0, 1'b0, 1'b1};
        exp_tab[6] = {6'd3, 16'h0000, 6'd0, 1'b0, 1'b1};
        exp_tab[7] = {6'd8, 16'h0000, 6'd0, 1'b0, 1'b0};
        exp_tab[8] = {6'd9, 16'h1008, 6'd9, 1'b1, 1'b0};
        mem[3] = 16'hF000;
        JUMP = 1'b1; JUMP_TARGET = 6'd0;
        for (int k = 0; k < 9; k++) begin
            step();
            clear_ctrl();
            if (k == 6) begin
                JUMP = 1'b1; JUMP_TARGET = 6'd8;
            end
            vectors++;
            if (obs !== exp_tab[k]) begin
                miscompares++;
                $display("FAIL halt%0d: got %h want %h", k, obs, exp_tab[k]);
            end
            $display("halt%0d: pc=%0d ifid=%h pc1=%0d v=%b h=%b", k, PCI, IFID_INSTR, IFID_PC1, IFID_VALID, HALTED);
        end
        mem[3] = 16'h1003;
    endtask

    task automatic test_reset_midrun();
        JUMP = 1'b1; JUMP_TARGET = 6'd40;
        step();
        clear_ctrl();
        step();
        exp_v = {6'd41, 16'h1028, 6'd41, 1'b1, 1'b0};
        vectors++;
        if (obs !== exp_v) begin
            miscompares++;
            $display("FAIL midrun_pre: got %h want %h", obs, exp_v);
        end
        RST = 1'b1; STALL = 1'b1; JUMP = 1'b1; JUMP_TARGET = 6'd30;
        step();
        clear_ctrl();
        exp_v = {6'd0, 16'h0000, 6'd0, 1'b0, 1'b0};
        vectors++;
        if (obs !== exp_v) begin
            miscompares++;
            $display("FAIL midrun_rst: got %h want %h", obs, exp_v);
        end
        $display("midrun_rst: pc=%0d ifid=%h v=%b h=%b", PCI, IFID_INSTR, IFID_VALID, HALTED);
        step();
        exp_v = {6'd1, 16'h1000, 6'd1, 1'b1, 1'b0};
        vectors++;
        if (obs !== exp_v) begin
            miscompares++;
            $display("FAIL midrun_post: got %h want %h", obs, exp_v);
        end
        $display("midrun_post: pc=%0d ifid=%h pc1=%0d v=%b", PCI, IFID_INSTR, IFID_PC1, IFID_VALID);
    endtask

    initial begin
        for (int i = 0; i < 64; i++) mem[i] = 16'h1000 + 16'(i);
        test_reset();
        test_sequential();
        test_jump_wrap();
        test_stall();
        test_priority();
        test_halt();
        test_reset_midrun();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
